// File: rtl/renode_ahb_arbiter.sv
// Round-robin AHB-Lite arbiter: N managers share one subordinate,
// single transfers only, with an optional wait-state timeout.
module renode_ahb_arbiter #(
    parameter int NumManagers   = 2,
    parameter int AddressWidth  = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 256
) (
    input  logic                                    hclk,
    input  logic                                    hresetn,
    input  logic [2*NumManagers-1:0]                m_htrans,
    input  logic [AddressWidth*NumManagers-1:0]     m_haddr,
    input  logic [NumManagers-1:0]                  m_hwrite,
    input  logic [3*NumManagers-1:0]                m_hsize,
    input  logic [3*NumManagers-1:0]                m_hburst,
    input  logic [DataWidth*NumManagers-1:0]        m_hwdata,
    input  logic [(DataWidth/8)*NumManagers-1:0]    m_hwstrb,
    output logic [NumManagers-1:0]                  m_hready,
    output logic [NumManagers-1:0]                  m_hresp,
    output logic [DataWidth-1:0]                    m_hrdata,
    output logic [1:0]                              s_htrans,
    output logic [AddressWidth-1:0]                 s_haddr,
    output logic                                    s_hwrite,
    output logic [2:0]                              s_hsize,
    output logic [2:0]                              s_hburst,
    output logic [DataWidth-1:0]                    s_hwdata,
    output logic [DataWidth/8-1:0]                  s_hwstrb,
    input  logic                                    s_hready,
    input  logic                                    s_hresp,
    input  logic [DataWidth-1:0]                    s_hrdata
);

    localparam int SW = DataWidth / 8;
    localparam int OW = $clog2(NumManagers);
    localparam int CW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TimeoutCycles);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_q, last_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic [NumManagers-1:0] req;
    logic [OW-1:0]   rr_pick;
    logic            rr_valid;
    logic            timeout;
    logic            unused_hburst;

    // Bursts are flattened to singles, so the manager burst type is ignored.
    assign unused_hburst = ^m_hburst;
    assign m_hrdata      = s_hrdata;
    assign timeout       = (TimeoutCycles != 0) && (state_q != IDLE)
                           && (wait_q == TO_VAL);

    always_comb begin
        req = '0;
        for (int i = 0; i < NumManagers; i++) begin
            req[i] = (m_htrans[2*i +: 2] != 2'b00);
        end
    end

    // First requester strictly after the previous grant.
    always_comb begin
        int idx;
        idx      = 0;
        rr_valid = 1'b0;
        rr_pick  = '0;
        for (int k = 1; k <= NumManagers; k++) begin
            idx = (int'(last_q) + k) % NumManagers;
            if (!rr_valid && req[idx]) begin
                rr_valid = 1'b1;
                rr_pick  = OW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: begin
                if (rr_valid) begin
                    owner_d = rr_pick;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (timeout) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end else if (s_hready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (timeout || s_hready) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (TimeoutCycles != 0 && state_q != IDLE
                     && !s_hready && wait_q != TO_VAL) begin
            wait_d = wait_q + CW'(1);
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NumManagers - 1);
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        int ow;
        ow       = int'(owner_q);
        s_htrans = 2'b00;
        s_haddr  = '0;
        s_hwrite = 1'b0;
        s_hsize  = 3'b000;
        s_hburst = 3'b000;
        s_hwdata = '0;
        s_hwstrb = '0;
        if (state_q == ADDR) begin
            s_htrans = 2'b10;
            s_haddr  = m_haddr[ow*AddressWidth +: AddressWidth];
            s_hwrite = m_hwrite[ow];
            s_hsize  = m_hsize[3*ow +: 3];
        end
        if (state_q == DATA) begin
            s_hwdata = m_hwdata[ow*DataWidth +: DataWidth];
            s_hwstrb = m_hwstrb[ow*SW +: SW];
        end
    end

    always_comb begin
        m_hready = '0;
        m_hresp  = '0;
        for (int i = 0; i < NumManagers; i++) begin
            if (state_q != IDLE && int'(owner_q) == i) begin
                m_hready[i] = timeout | s_hready;
                m_hresp[i]  = timeout | ((state_q == DATA) & s_hresp);
            end else begin
                m_hready[i] = ~req[i];
                m_hresp[i]  = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_renode_ahb_arbiter.sv
// Directed bench for renode_ahb_arbiter with two managers
// and a short timeout.
module tb_renode_ahb_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            hclk = 1'b0;
    logic            hresetn;
    logic [2*N-1:0]  m_htrans;
    logic [AW*N-1:0] m_haddr;
    logic [N-1:0]    m_hwrite;
    logic [3*N-1:0]  m_hsize;
    logic [3*N-1:0]  m_hburst;
    logic [DW*N-1:0] m_hwdata;
    logic [SW*N-1:0] m_hwstrb;
    logic [N-1:0]    m_hready;
    logic [N-1:0]    m_hresp;
    logic [DW-1:0]   m_hrdata;
    logic [1:0]      s_htrans;
    logic [AW-1:0]   s_haddr;
    logic            s_hwrite;
    logic [2:0]      s_hsize;
    logic [2:0]      s_hburst;
    logic [DW-1:0]   s_hwdata;
    logic [SW-1:0]   s_hwstrb;
    logic            s_hready;
    logic            s_hresp;
    logic [DW-1:0]   s_hrdata;

    int vectors = 0;
    int miscompares = 0;

    renode_ahb_arbiter #(
        .NumManagers(N), .AddressWidth(AW),
        .DataWidth(DW), .TimeoutCycles(4)
    ) dut (
        .hclk(hclk), .hresetn(hresetn),
        .m_htrans(m_htrans), .m_haddr(m_haddr), .m_hwrite(m_hwrite),
        .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hwdata(m_hwdata),
        .m_hwstrb(m_hwstrb), .m_hready(m_hready), .m_hresp(m_hresp),
        .m_hrdata(m_hrdata),
        .s_htrans(s_htrans), .s_haddr(s_haddr), .s_hwrite(s_hwrite),
        .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hwdata(s_hwdata),
        .s_hwstrb(s_hwstrb), .s_hready(s_hready), .s_hresp(s_hresp),
        .s_hrdata(s_hrdata)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        @(negedge hclk);
    endtask

    task automatic set_m(input int i, input logic [1:0] tr,
                         input logic [31:0] a, input logic w,
                         input logic [31:0] d);
        m_htrans[2*i +: 2]   = tr;
        m_haddr[AW*i +: AW]  = a;
        m_hwrite[i]          = w;
        m_hsize[3*i +: 3]    = 3'b010;
        m_hwdata[DW*i +: DW] = d;
        m_hwstrb[SW*i +: SW] = 4'hF;
    endtask

    task automatic do_reset();
        hresetn = 1'b0;
        #1;
        @(negedge hclk);
        hresetn = 1'b1;
    endtask

    initial begin
        hresetn  = 1'b0;
        m_htrans = '0;
        m_haddr  = '0;
        m_hwrite = '0;
        m_hsize  = '0;
        m_hburst = '0;
        m_hwdata = '0;
        m_hwstrb = '0;
        s_hready = 1'b1;
        s_hresp  = 1'b0;
        s_hrdata = '0;
        #1;
        chk("rst_htrans", 64'(s_htrans), 64'h0);
        chk("rst_hready", 64'(m_hready), 64'h3);
        chk("rst_hresp", 64'(m_hresp), 64'h0);
        @(negedge hclk);
        hresetn = 1'b1;

        // single write from m0
        set_m(0, 2'b10, 32'h1000, 1'b1, 32'hDEADBEEF);
        #1;
        chk("wr_idle_hready", 64'(m_hready), 64'h2);
        tick();
        chk("wr_addr_htrans", 64'(s_htrans), 64'h2);
        chk("wr_addr_haddr", 64'(s_haddr), 64'h1000);
        chk("wr_addr_hwrite", 64'(s_hwrite), 64'h1);
        chk("wr_addr_hwdata", 64'(s_hwdata), 64'h0);
        m_htrans[1:0] = 2'b00;
        tick();
        chk("wr_data_htrans", 64'(s_htrans), 64'h0);
        chk("wr_data_haddr", 64'(s_haddr), 64'h0);
        chk("wr_data_hwdata", 64'(s_hwdata), 64'hDEADBEEF);
        chk("wr_data_hwstrb", 64'(s_hwstrb), 64'hF);
        chk("wr_data_hready", 64'(m_hready), 64'h3);
        tick();
        chk("wr_done_hwdata", 64'(s_hwdata), 64'h0);

        // simultaneous requests after a fresh reset
        do_reset();
        set_m(0, 2'b10, 32'h2000, 1'b0, 32'h0);
        set_m(1, 2'b11, 32'h3000, 1'b0, 32'h0);
        tick();
        chk("tie_first_haddr", 64'(s_haddr), 64'h2000);
        chk("tie_m1_held", 64'(m_hready), 64'h1);
        m_htrans[1:0] = 2'b00;
        tick();
        s_hrdata = 32'hCAFEF00D;
        #1;
        chk("tie_hrdata", 64'(m_hrdata), 64'hCAFEF00D);
        chk("tie_data_hready", 64'(m_hready), 64'h1);
        tick();
        chk("tie_gap_htrans", 64'(s_htrans), 64'h0);
        chk("tie_gap_hready", 64'(m_hready), 64'h1);
        tick();
        chk("tie_second_haddr", 64'(s_haddr), 64'h3000);
        m_htrans[3:2] = 2'b00;
        tick();
        tick();
        set_m(0, 2'b10, 32'h2000, 1'b0, 32'h0);
        set_m(1, 2'b10, 32'h3000, 1'b0, 32'h0);
        tick();
        chk("tie_again_haddr", 64'(s_haddr), 64'h2000);
        m_htrans = '0;
        tick();
        tick();
        tick();
        chk("withdrawn_htrans", 64'(s_htrans), 64'h0);

        // read with three data wait states
        set_m(1, 2'b10, 32'h4000, 1'b0, 32'h0);
        tick();
        chk("rd_addr_haddr", 64'(s_haddr), 64'h4000);
        chk("rd_addr_hwrite", 64'(s_hwrite), 64'h0);
        m_htrans = '0;
        tick();
        s_hready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("rd_wait_hready", 64'(m_hready[1]), 64'h0);
            tick();
        end
        s_hready = 1'b1;
        s_hrdata = 32'h12345678;
        #1;
        chk("rd_done_hready", 64'(m_hready[1]), 64'h1);
        chk("rd_done_hresp", 64'(m_hresp[1]), 64'h0);
        chk("rd_done_hrdata", 64'(m_hrdata), 64'h12345678);
        tick();

        // two-cycle error response to m0
        set_m(0, 2'b10, 32'h5000, 1'b1, 32'h55AA55AA);
        tick();
        m_htrans = '0;
        tick();
        s_hready = 1'b0;
        s_hresp  = 1'b1;
        #1;
        chk("err1_hresp", 64'(m_hresp), 64'h1);
        chk("err1_hready", 64'(m_hready), 64'h2);
        tick();
        s_hready = 1'b1;
        #1;
        chk("err2_hresp", 64'(m_hresp), 64'h1);
        chk("err2_hready", 64'(m_hready), 64'h3);
        tick();
        s_hresp = 1'b0;

        // timeout while subordinate is stuck
        set_m(1, 2'b10, 32'h6000, 1'b0, 32'h0);
        s_hready = 1'b0;
        tick();
        chk("to_addr_haddr", 64'(s_haddr), 64'h6000);
        chk("to_wait0_hready", 64'(m_hready[1]), 64'h0);
        tick();
        tick();
        tick();
        chk("to_wait3_hready", 64'(m_hready[1]), 64'h0);
        tick();
        chk("to_fire_hready", 64'(m_hready[1]), 64'h1);
        chk("to_fire_hresp", 64'(m_hresp[1]), 64'h1);
        m_htrans = '0;
        tick();
        chk("to_idle_htrans", 64'(s_htrans), 64'h0);
        chk("to_idle_hready", 64'(m_hready), 64'h3);
        s_hready = 1'b1;

        // reset in the middle of a data phase
        set_m(0, 2'b10, 32'h7000, 1'b1, 32'hA5A5A5A5);
        tick();
        m_htrans = '0;
        tick();
        chk("mid_data_hwdata", 64'(s_hwdata), 64'hA5A5A5A5);
        set_m(1, 2'b10, 32'h8000, 1'b0, 32'h0);
        #1;
        chk("mid_nonowner", 64'(m_hready), 64'h1);
        hresetn = 1'b0;
        #1;
        chk("mid_rst_htrans", 64'(s_htrans), 64'h0);
        chk("mid_rst_hwdata", 64'(s_hwdata), 64'h0);
        chk("mid_rst_hready", 64'(m_hready), 64'h1);
        @(negedge hclk);
        hresetn = 1'b1;
        tick();
        chk("post_rst_haddr", 64'(s_haddr), 64'h8000);
        chk("post_rst_htrans", 64'(s_htrans), 64'h2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/renode_ahb_arbiter.md
RENODE_AHB_ARBITER -- requirements
Module: renode_ahb_arbiter

Interface
REQ-001 The block SHALL have parameter NumManagers, default 2, legal range 2..8: number of manager ports.
REQ-002 The block SHALL have parameter AddressWidth, default 32: haddr width.
REQ-003 The block SHALL have parameter DataWidth, default 32, legal values 8/16/32/64: hwdata/hrdata width, with strobe width DataWidth/8.
REQ-004 The block SHALL have parameter TimeoutCycles, default 256: wait-state limit; 0 disables the limit.
REQ-005 Ports SHALL be: hclk  in  1  single clock, rising edge; hresetn  in  1  asynchronous active-low reset.
REQ-006 Manager ports, each packed as NumManagers slices with index i = manager i, SHALL be: m_htrans in 2*N; m_haddr in AddressWidth*N; m_hwrite in N; m_hsize in 3*N; m_hburst in 3*N; m_hwdata in DataWidth*N; m_hwstrb in (DataWidth/8)*N; m_hready out N; m_hresp out N; m_hrdata out DataWidth, broadcast to all managers.
REQ-007 Subordinate ports SHALL be: s_htrans out 2; s_haddr out AddressWidth; s_hwrite out 1; s_hsize out 3; s_hburst out 3; s_hwdata out DataWidth; s_hwstrb out DataWidth/8; s_hready in 1; s_hresp in 1; s_hrdata in DataWidth.

Function
REQ-008 The block SHALL implement FSM states IDLE, ADDR and DATA, plus an owner register (log2 N bits) and a last_grant register.
REQ-009 A manager i SHALL be requesting when m_htrans[i] != Idle (2'b00); SEQ and BUSY SHALL be treated as NONSEQ, because only single transfers are supported.
REQ-010 In IDLE with at least one request, the block SHALL, at the next edge, set owner to the first requester after last_grant in round-robin order and enter ADDR.
REQ-011 In ADDR, s_htrans SHALL be NonSequential (2'b10) and s_haddr/s_hwrite/s_hsize SHALL be combinational copies of the owner's inputs; s_hburst SHALL be Single (0).
REQ-012 In ADDR, an edge with s_hready=1 SHALL move the FSM to DATA.
REQ-013 In DATA, s_htrans SHALL be Idle, address-phase outputs SHALL be 0, and s_hwdata/s_hwstrb SHALL be the owner's m_hwdata/m_hwstrb.
REQ-014 In DATA, an edge with s_hready=1 SHALL return the FSM to IDLE and set last_grant to owner.
REQ-015 In states other than DATA, s_hwdata and s_hwstrb SHALL be 0.
REQ-016 In IDLE, all subordinate outputs SHALL be 0 and s_htrans SHALL be Idle.
REQ-017 The owner's m_hready SHALL equal s_hready in ADDR and DATA.
REQ-018 The owner's m_hresp SHALL equal s_hresp in DATA and SHALL be 0 in ADDR.
REQ-019 A non-owner, or any manager while the FSM is IDLE, SHALL see m_hready=0 if requesting and 1 otherwise, with m_hresp=0 (Okay).
REQ-020 m_hrdata SHALL equal s_hrdata at all times.
REQ-021 Minimum transfer latency, counted from a request sampled in IDLE to the owner's data-phase completion with zero wait states, SHALL be 3 edges; back-to-back grants SHALL have 1 IDLE cycle between transfers.
REQ-022 A wait counter SHALL clear on every state change.
REQ-023 The wait counter SHALL increment each ADDR/DATA cycle with s_hready=0 and SHALL saturate at TimeoutCycles.
REQ-024 When the wait counter reaches TimeoutCycles (non-zero), the block SHALL drive owner m_hready=1 and m_hresp=1 for exactly one cycle, then go to IDLE and update last_grant.
REQ-025 Any m_htrans change from a non-owner SHALL NOT affect the current transfer.
REQ-026 A request withdrawn before grant SHALL NOT be granted.

Reset
REQ-027 On hresetn=0 the block SHALL asynchronously enter IDLE with owner=0, last_grant=NumManagers-1 and wait counter=0, and all subordinate outputs SHALL be 0.
REQ-028 During reset, m_hready SHALL be 1 for non-requesting managers and m_hresp SHALL be 0; a transfer in progress SHALL be abandoned without a response.
REQ-029 After release, the first grant SHALL go to manager 0 when multiple managers request.

Verification
REQ-030 Single write: after reset, m0 NONSEQ write to 0x1000 with data 0xDEADBEEF and zero waits -> s_haddr=0x1000 in ADDR; s_hwdata=0xDEADBEEF in DATA; m_hready[0]=1 on the 3rd edge.
REQ-031 Simultaneous requests: m0 and m1 request in the same cycle -> m0 served first and m1 held at m_hready=0; then m1 served; a subsequent tie goes to m0.
REQ-032 Wait states: s_hready=0 for 3 DATA cycles on a read -> m_hready[owner]=0 for those 3 cycles; the read returns s_hrdata=0x12345678 with hresp=0.
REQ-033 Error response: subordinate drives hresp=1 with hready 0 then 1 -> owner sees m_hresp=1 for both cycles; the other manager sees 0.
REQ-034 Timeout: TimeoutCycles=4 with s_hready stuck at 0 -> after 4 wait cycles the owner gets m_hready=1 and m_hresp=1; FSM returns to IDLE.
REQ-035 Reset mid-transfer: hresetn low in DATA -> s_htrans=0 and s_hwdata=0 immediately; after release, m1 requesting alone is granted.
